// File: rtl/multiplier.sv
// Two-stage 32x32 unsigned multiplier with one operation per cycle.
// Ports: clk, reset (async high), op1/op2/en in; res[64:0]/val/overflow out.
module multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        en,
  output logic [64:0] res,
  output logic        val,
  output logic        overflow
);

  logic [31:0] pp_ll_q, pp_ll_d;
  logic [31:0] pp_lh_q, pp_lh_d;
  logic [31:0] pp_hl_q, pp_hl_d;
  logic [31:0] pp_hh_q, pp_hh_d;
  logic        v1_q, v1_d;

  logic [64:0] res_q, res_d;
  logic        val_q, val_d;
  logic        ovf_q, ovf_d;

  logic [63:0] prod;

  always_comb begin
    pp_ll_d = pp_ll_q;
    pp_lh_d = pp_lh_q;
    pp_hl_d = pp_hl_q;
    pp_hh_d = pp_hh_q;
    v1_d    = en;
    if (en) begin
      pp_ll_d = op1[15:0]  * op2[15:0];
      pp_lh_d = op1[15:0]  * op2[31:16];
      pp_hl_d = op1[31:16] * op2[15:0];
      pp_hh_d = op1[31:16] * op2[31:16];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      pp_hh_q <= '0;
      v1_q    <= 1'b0;
    end else begin
      pp_ll_q <= pp_ll_d;
      pp_lh_q <= pp_lh_d;
      pp_hl_q <= pp_hl_d;
      pp_hh_q <= pp_hh_d;
      v1_q    <= v1_d;
    end
  end

  // Cross terms sit at bit 16; the full sum never exceeds 64 bits.
  assign prod = {32'b0, pp_ll_q}
              + {16'b0, pp_lh_q, 16'b0}
              + {16'b0, pp_hl_q, 16'b0}
              + {pp_hh_q, 32'b0};

  always_comb begin
    res_d = res_q;
    ovf_d = ovf_q;
    val_d = v1_q;
    if (v1_q) begin
      res_d = {1'b0, prod};
      ovf_d = |prod[63:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      val_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      res_q <= res_d;
      val_q <= val_d;
      ovf_q <= ovf_d;
    end
  end

  assign res      = res_q;
  assign val      = val_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: scoreboard plus directed values.
// Drives inputs and samples outputs 1ns after each rising edge.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        en = 1'b0;
  logic [64:0] res;
  logic        val;
  logic        overflow;

  int total = 0;
  int bad = 0;

  logic [65:0] sb[$];
  logic        s1 = 1'b0;
  logic [64:0] hold_res = '0;
  logic        hold_ovf = 1'b0;

  multiplier dut (
    .clk      (clk),
    .reset    (reset),
    .op1      (op1),
    .op2      (op2),
    .en       (en),
    .res      (res),
    .val      (val),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [64:0] obs,
                     input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic e,
                     input logic [31:0] a,
                     input logic [31:0] b);
    logic        s1n;
    logic        ev;
    logic [63:0] p;
    logic [65:0] item;
    en  = e;
    op1 = a;
    op2 = b;
    s1n = e && !reset;
    if (s1n) begin
      p = 64'(a) * 64'(b);
      sb.push_back({(p > 64'hFFFF_FFFF), 1'b0, p});
    end
    @(posedge clk);
    #1;
    ev = s1;
    s1 = s1n;
    chk("val", 65'(val), 65'(ev));
    if (ev) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 65'd1, 65'd0);
      end else begin
        item = sb.pop_front();
        hold_res = item[64:0];
        hold_ovf = item[65];
      end
    end
    chk("res", res, hold_res);
    chk("ovf", 65'(overflow), 65'(hold_ovf));
  endtask

  task automatic go_reset();
    reset = 1'b1;
    #1;
    sb.delete();
    s1 = 1'b0;
    hold_res = '0;
    hold_ovf = 1'b0;
    chk("rst_res", res, 65'd0);
    chk("rst_val", 65'(val), 65'd0);
    chk("rst_ovf", 65'(overflow), 65'd0);
  endtask

  initial begin
    #1;
    go_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 7, 7);
    reset = 1'b0;

    cyc(1, 48, 56);
    cyc(0, 0, 0);
    chk("r24_res", res, 65'd2688);
    chk("r24_val", 65'(val), 65'd1);
    chk("r24_ovf", 65'(overflow), 65'd0);
    cyc(0, 1, 1);
    chk("r24_hold", res, 65'd2688);
    chk("r24_vdrop", 65'(val), 65'd0);

    cyc(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(1, 32'h0000_FFFF, 32'h0000_FFFF);
    chk("r25_res", res, 65'h0_FFFF_FFFE_0000_0001);
    chk("r25_ovf", 65'(overflow), 65'd1);
    cyc(1, 32'h0001_0000, 32'h0001_0000);
    chk("r26a_res", res, 65'h0_0000_0000_FFFE_0001);
    chk("r26a_ovf", 65'(overflow), 65'd0);
    cyc(0, 0, 0);
    chk("r26b_res", res, 65'h1_0000_0000);
    chk("r26b_ovf", 65'(overflow), 65'd1);
    cyc(0, 0, 0);

    cyc(1, 3, 5);
    cyc(1, 0, 123);
    chk("r27_a", res, 65'd15);
    cyc(1, 7, 9);
    chk("r27_b", res, 65'd0);
    cyc(0, 0, 0);
    chk("r27_c", res, 65'd63);
    chk("r27_v", 65'(val), 65'd1);
    cyc(0, 0, 0);

    cyc(1, 1000, 3);
    cyc(0, 5, 5);
    chk("r18", res, 65'd3000);
    cyc(0, 9, 9);

    cyc(1, 100, 100);
    go_reset();
    cyc(0, 0, 0);
    cyc(1, 4, 4);
    reset = 1'b0;
    en = 1'b0;
    cyc(0, 0, 0);
    chk("r28_val", 65'(val), 65'd0);
    chk("r28_res", res, 65'd0);
    cyc(0, 0, 0);
    cyc(1, 12, 12);
    cyc(0, 0, 0);
    chk("r28_next", res, 65'd144);

    for (int i = 0; i < 40; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("sb_drain", 65'(sb.size()), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
